nearest_block_gatherer: RTL and testbench



---
 rtl/nearest_block_gatherer.sv | 225 ++++++++++++++++++++++
 tb/tb_nearest_block_gatherer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nearest_block_gatherer.sv
// nearest_block_gatherer: scans the z-sorted block memory once per frame and
// publishes the (up to) 12 nearest upcoming blocks as a double-buffered snapshot.
// Optional build macro: NEAREST_GATHER_RESUME_EN (scan resumes from the first
// not-yet-passed block of the previous frame instead of address 0).
module nearest_block_gatherer #(
    parameter int NUM_BLOCKS  = 256,
    parameter int WINDOW_Z    = 2048,
    parameter int MEM_LATENCY = 2
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          frame_start_in,
    input  logic [17:0]                   curr_time_in,
    output logic [$clog2(NUM_BLOCKS)-1:0] mem_addr_out,
    input  logic [29:0]                   mem_data_in,
    input  logic [13:0]                   mem_z_in,
    output logic [11:0][11:0]             block_x_out,
    output logic [11:0][11:0]             block_y_out,
    output logic [11:0][13:0]             block_z_out,
    output logic [11:0]                   block_color_out,
    output logic [11:0][2:0]              block_direction_out,
    output logic [11:0][7:0]              block_ID_out,
    output logic [11:0]                   block_visible_out,
    output logic                          busy_out,
    output logic                          commit_out,
    output logic                          overrun_out
);
    localparam int            AW        = $clog2(NUM_BLOCKS);
    localparam int            NSLOT     = 12;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_BLOCKS - 1);
    localparam logic [13:0]   SENTINEL  = 14'h3FFF;
    localparam logic [31:0]   WIN       = 32'(WINDOW_Z);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} state_t;

    state_t r_state, w_state_next;

    logic [13:0]                      r_time_z;
    logic [AW-1:0]                    r_addr;
    logic                             r_issue;
    logic [3:0]                       r_count;
    logic [MEM_LATENCY-1:0]           r_pipe_v;
    logic [MEM_LATENCY-1:0][AW-1:0]   r_pipe_a;

    logic [NSLOT-1:0][11:0] r_sh_x, r_sh_y;
    logic [NSLOT-1:0][13:0] r_sh_z;
    logic [NSLOT-1:0]       r_sh_col;
    logic [NSLOT-1:0][2:0]  r_sh_dir;
    logic [NSLOT-1:0][7:0]  r_sh_id;

    logic [NSLOT-1:0][11:0] r_x, r_y;
    logic [NSLOT-1:0][13:0] r_z;
    logic [NSLOT-1:0]       r_col;
    logic [NSLOT-1:0][2:0]  r_dir;
    logic [NSLOT-1:0][7:0]  r_id;
    logic [NSLOT-1:0]       r_vis;
    logic                   r_busy, r_commit, r_overrun;

    logic          w_issue, w_valid, w_passed, w_sentinel, w_in_win;
    logic          w_accept, w_stop;
    logic [AW-1:0] w_cur_addr, w_start_addr;
    logic [13:0]   w_rel;
    logic          w_unused;

    assign w_issue    = (r_state == S_SCAN) && r_issue;
    assign w_valid    = (r_state == S_SCAN) && r_pipe_v[MEM_LATENCY-1];
    assign w_cur_addr = r_pipe_a[MEM_LATENCY-1];
    assign w_passed   = mem_z_in < r_time_z;
    assign w_rel      = w_passed ? '0 : (mem_z_in - r_time_z);
    assign w_sentinel = (mem_z_in == SENTINEL);
    assign w_in_win   = {18'd0, w_rel} < WIN;
    assign w_accept   = w_valid && !w_sentinel && !w_passed && w_in_win;
    assign w_stop     = w_valid && (w_sentinel || (!w_passed && !w_in_win) ||
                                    (w_accept && (r_count == 4'd11)) ||
                                    (w_cur_addr == LAST_ADDR));
    assign w_unused   = ^{mem_data_in[1:0], curr_time_in[3:0]};

`ifdef NEAREST_GATHER_RESUME_EN
    logic [AW-1:0] r_resume, r_first_addr;
    logic          r_first_found;

    assign w_start_addr = (curr_time_in[17:4] >= r_time_z) ? r_resume : '0;

    // Remember the first not-yet-passed word of this scan; publish it at commit.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_resume      <= '0;
            r_first_addr  <= '0;
            r_first_found <= 1'b0;
        end else begin
            if (r_state == S_IDLE && frame_start_in) begin
                r_first_found <= 1'b0;
            end else if (w_valid && !w_passed && !r_first_found) begin
                r_first_found <= 1'b1;
                r_first_addr  <= w_cur_addr;
            end
            if (r_state == S_COMMIT && r_first_found) begin
                r_resume <= r_first_addr;
            end
        end
    end
`else
    assign w_start_addr = '0;
`endif

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (frame_start_in) w_state_next = S_SCAN;
            S_SCAN:   if (w_stop)         w_state_next = S_COMMIT;
            S_COMMIT: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Read-tag pipeline: marks which returning words belong to this scan;
    // flushed outside SCAN and on a stop so in-flight reads are discarded.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_pipe_v <= '0;
            r_pipe_a <= '0;
        end else if (r_state != S_SCAN || w_stop) begin
            r_pipe_v <= '0;
        end else begin
            r_pipe_v[0] <= w_issue;
            r_pipe_a[0] <= r_addr;
            for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
                r_pipe_v[i] <= r_pipe_v[i-1];
                r_pipe_a[i] <= r_pipe_a[i-1];
            end
        end
    end

    // Scan datapath: address issue, shadow fill, commit to the output snapshot.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_time_z  <= '0;
            r_addr    <= '0;
            r_issue   <= 1'b0;
            r_count   <= '0;
            r_sh_x    <= '0;
            r_sh_y    <= '0;
            r_sh_z    <= '0;
            r_sh_col  <= '0;
            r_sh_dir  <= '0;
            r_sh_id   <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_z       <= '0;
            r_col     <= '0;
            r_dir     <= '0;
            r_id      <= '0;
            r_vis     <= '0;
            r_busy    <= 1'b0;
            r_commit  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_commit  <= 1'b0;
            r_overrun <= frame_start_in && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (frame_start_in) begin
                        r_time_z <= curr_time_in[17:4];
                        r_addr   <= w_start_addr;
                        r_issue  <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (w_issue && !w_stop) begin
                        if (r_addr == LAST_ADDR) r_issue <= 1'b0;
                        else                     r_addr  <= r_addr + 1'b1;
                    end
                    if (w_accept) begin
                        r_sh_x[r_count]   <= mem_data_in[29:18];
                        r_sh_y[r_count]   <= mem_data_in[17:6];
                        r_sh_dir[r_count] <= mem_data_in[5:3];
                        r_sh_col[r_count] <= mem_data_in[2];
                        r_sh_z[r_count]   <= w_rel;
                        r_sh_id[r_count]  <= 8'(w_cur_addr);
                        r_count           <= r_count + 4'd1;
                    end
                end
                S_COMMIT: begin
                    for (int unsigned i = 0; i < NSLOT; i++) begin
                        if (i < 32'(r_count)) begin
                            r_x[i]   <= r_sh_x[i];
                            r_y[i]   <= r_sh_y[i];
                            r_z[i]   <= r_sh_z[i];
                            r_col[i] <= r_sh_col[i];
                            r_dir[i] <= r_sh_dir[i];
                            r_id[i]  <= r_sh_id[i];
                            r_vis[i] <= 1'b1;
                        end else begin
                            r_vis[i] <= 1'b0;
                        end
                    end
                    r_count  <= '0;
                    r_commit <= 1'b1;
                    r_busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr_out        = r_addr;
    assign block_x_out         = r_x;
    assign block_y_out         = r_y;
    assign block_z_out         = r_z;
    assign block_color_out     = r_col;
    assign block_direction_out = r_dir;
    assign block_ID_out        = r_id;
    assign block_visible_out   = r_vis;
    assign busy_out            = r_busy;
    assign commit_out          = r_commit;
    assign overrun_out         = r_overrun;
endmodule

// File: tb/tb_nearest_block_gatherer.sv
// Bench for nearest_block_gatherer: instance 0 uses WINDOW_Z=2048, instance 1
// uses WINDOW_Z=250. Memory holds z = 0,100,...,2000 at addresses 0..20 and the
// sentinel everywhere above.
module tb_nearest_block_gatherer;
    localparam int NB = 256;

`ifdef NEAREST_GATHER_RESUME_EN
    localparam int T3_FIRST = 10;
    localparam int T3_CYC   = 16;
`else
    localparam int T3_FIRST = 0;
    localparam int T3_CYC   = 26;
`endif

    typedef struct {
        logic [11:0][11:0] x;
        logic [11:0][11:0] y;
        logic [11:0][13:0] z;
        logic [11:0]       col;
        logic [11:0][2:0]  dir;
        logic [11:0][7:0]  id;
        logic [11:0]       vis;
    } snap_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              fs     [2];
    logic [17:0]       tm     [2];
    logic [7:0]        addr   [2];
    logic [29:0]       d1     [2];
    logic [29:0]       d2     [2];
    logic [13:0]       z1     [2];
    logic [13:0]       z2     [2];
    logic [11:0][11:0] bx     [2];
    logic [11:0][11:0] by     [2];
    logic [11:0][13:0] bz     [2];
    logic [11:0]       bcol   [2];
    logic [11:0][2:0]  bdir   [2];
    logic [11:0][7:0]  bid    [2];
    logic [11:0]       bvis   [2];
    logic              busy   [2];
    logic              commit [2];
    logic              ovr    [2];

    int    n_checks = 0;
    int    n_fail   = 0;
    snap_t exp_q [$];
    snap_t prev  [2];

    function automatic logic [13:0] mz(input int a);
        return (a < 21) ? 14'(a * 100) : 14'h3FFF;
    endfunction

    function automatic logic [29:0] md(input int a);
        logic [11:0] x, y;
        x = 12'(a * 3 + 1);
        y = 12'(a * 5 + 2);
        return {x, y, 3'(a % 8), a[0], 2'b10};
    endfunction

    // Two-cycle-latency block memory per instance.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            d1[k] <= md(int'(addr[k]));
            z1[k] <= mz(int'(addr[k]));
            d2[k] <= d1[k];
            z2[k] <= z1[k];
        end
    end

    nearest_block_gatherer #(.NUM_BLOCKS(NB), .WINDOW_Z(2048), .MEM_LATENCY(2)) u_dut0 (
        .clk_in(clk), .rst_in(rst), .frame_start_in(fs[0]), .curr_time_in(tm[0]),
        .mem_addr_out(addr[0]), .mem_data_in(d2[0]), .mem_z_in(z2[0]),
        .block_x_out(bx[0]), .block_y_out(by[0]), .block_z_out(bz[0]),
        .block_color_out(bcol[0]), .block_direction_out(bdir[0]), .block_ID_out(bid[0]),
        .block_visible_out(bvis[0]), .busy_out(busy[0]), .commit_out(commit[0]),
        .overrun_out(ovr[0]));

    nearest_block_gatherer #(.NUM_BLOCKS(NB), .WINDOW_Z(250), .MEM_LATENCY(2)) u_dut1 (
        .clk_in(clk), .rst_in(rst), .frame_start_in(fs[1]), .curr_time_in(tm[1]),
        .mem_addr_out(addr[1]), .mem_data_in(d2[1]), .mem_z_in(z2[1]),
        .block_x_out(bx[1]), .block_y_out(by[1]), .block_z_out(bz[1]),
        .block_color_out(bcol[1]), .block_direction_out(bdir[1]), .block_ID_out(bid[1]),
        .block_visible_out(bvis[1]), .busy_out(busy[1]), .commit_out(commit[1]),
        .overrun_out(ovr[1]));

    // Reference: walk the memory from address 0 and pick the nearest blocks.
    function automatic snap_t model(input snap_t p, input logic [13:0] tz, input int win);
        snap_t s;
        int cnt;
        s = p;
        cnt = 0;
        for (int a = 0; a < NB; a++) begin
            logic [13:0] zz;
            logic [29:0] dd;
            zz = mz(a);
            dd = md(a);
            if (zz == 14'h3FFF) break;
            if (zz < tz) continue;
            if (int'(zz - tz) >= win) break;
            s.x[cnt]   = dd[29:18];
            s.y[cnt]   = dd[17:6];
            s.dir[cnt] = dd[5:3];
            s.col[cnt] = dd[2];
            s.z[cnt]   = zz - tz;
            s.id[cnt]  = 8'(a);
            cnt++;
            if (cnt == 12) break;
        end
        for (int i = 0; i < 12; i++) s.vis[i] = (i < cnt);
        return s;
    endfunction

    function automatic snap_t act(input int w);
        snap_t s;
        s.x = bx[w]; s.y = by[w]; s.z = bz[w]; s.col = bcol[w];
        s.dir = bdir[w]; s.id = bid[w]; s.vis = bvis[w];
        return s;
    endfunction

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic cmp_snap(input string tag, input snap_t a, input snap_t e);
        check({tag, "_vis"}, 192'(a.vis), 192'(e.vis));
        check({tag, "_x"},   192'(a.x),   192'(e.x));
        check({tag, "_y"},   192'(a.y),   192'(e.y));
        check({tag, "_z"},   192'(a.z),   192'(e.z));
        check({tag, "_col"}, 192'(a.col), 192'(e.col));
        check({tag, "_dir"}, 192'(a.dir), 192'(e.dir));
        check({tag, "_id"},  192'(a.id),  192'(e.id));
    endtask

    // Pulse frame_start; returns at the first negedge after the sampling edge.
    task automatic start_scan(input string tag, input int w, input logic [17:0] t,
                              input int win, input int first);
        snap_t e;
        e = model(prev[w], t[17:4], win);
        prev[w] = e;
        exp_q.push_back(e);
        @(negedge clk);
        fs[w] = 1'b1;
        tm[w] = t;
        @(negedge clk);
        fs[w] = 1'b0;
        check({tag, "_busy_up"},    192'(busy[w]), 192'(1));
        check({tag, "_first_addr"}, 192'(addr[w]), 192'(first));
    endtask

    // n0 = cycle index (after the start edge) of the current negedge.
    task automatic wait_compare(input string tag, input int w, input int n0, input int cyc);
        int n;
        snap_t e;
        n = n0;
        while (commit[w] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_commit_seen"},  192'(commit[w]), 192'(1));
        check({tag, "_commit_cycle"}, 192'(n), 192'(cyc));
        check({tag, "_busy_fell"},    192'(busy[w]), 192'(0));
        e = exp_q.pop_front();
        cmp_snap(tag, act(w), e);
        @(negedge clk);
        check({tag, "_commit_pulse"}, 192'(commit[w]), 192'(0));
    endtask

    task automatic check_reset_state(input string tag);
        snap_t z0;
        z0 = '{default: '0};
        cmp_snap(tag, act(0), z0);
        check({tag, "_busy"},   192'(busy[0]),   192'(0));
        check({tag, "_commit"}, 192'(commit[0]), 192'(0));
        check({tag, "_ovr"},    192'(ovr[0]),    192'(0));
        check({tag, "_addr"},   192'(addr[0]),   192'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int extra;
        rst = 1'b1;
        fs[0] = 1'b0; fs[1] = 1'b0;
        tm[0] = '0;   tm[1] = '0;
        prev[0] = '{default: '0};
        prev[1] = '{default: '0};
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        // Full 12-candidate scan from time 0.
        start_scan("t0", 0, 18'd0, 2048, 0);
        wait_compare("t0", 0, 1, 16);
        // time_z = 1000: blocks 10..20, 11 visible, stop on sentinel.
        start_scan("t1000", 0, 18'd16000, 2048, 0);
        wait_compare("t1000", 0, 1, 26);
        // time_z = 1500: resume point applies when enabled.
        start_scan("t1500", 0, 18'd24000, 2048, T3_FIRST);
        wait_compare("t1500", 0, 1, T3_CYC);
        // Song restart: time goes backwards.
        start_scan("restart", 0, 18'd0, 2048, 0);
        wait_compare("restart", 0, 1, 16);
        // Beyond the last block: nothing visible, stop on sentinel.
        start_scan("beyond", 0, 18'd80000, 2048, 0);
        wait_compare("beyond", 0, 1, 26);

        // Overrun: second frame_start 5 cycles in is ignored.
        start_scan("ovr", 0, 18'd0, 2048, 0);
        repeat (4) @(negedge clk);
        fs[0] = 1'b1;
        tm[0] = 18'd16000;
        @(negedge clk);
        fs[0] = 1'b0;
        check("ovr_pulse", 192'(ovr[0]), 192'(1));
        @(negedge clk);
        check("ovr_pulse_end", 192'(ovr[0]), 192'(0));
        wait_compare("ovr", 0, 7, 16);
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (commit[0] === 1'b1) extra++;
        end
        check("ovr_single_commit", 192'(extra), 192'(0));

        // Reset mid-scan: no commit, everything back to reset values.
        @(negedge clk);
        fs[0] = 1'b1;
        tm[0] = 18'd0;
        @(negedge clk);
        fs[0] = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("midrst");
        rst = 1'b0;
        prev[0] = '{default: '0};
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (commit[0] === 1'b1) extra++;
        end
        check("midrst_no_commit", 192'(extra), 192'(0));

        // Post-reset scan works normally.
        start_scan("post", 0, 18'd0, 2048, 0);
        wait_compare("post", 0, 1, 16);

        // Narrow window: 3 visible, stop on the z=300 word.
        start_scan("win", 1, 18'd0, 250, 0);
        wait_compare("win", 1, 1, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
